// File: rtl/alu_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq_pkg
//  Description : Shared definitions for the ALU multiply sequencer.
//                - sequencer state encoding (IDLE/ADD/SHR/FIN)
//                - ALU op codes understood by alu_6502
//                - product width and last step index
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_mul_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_SHR  = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_t;

    // ALU op codes (op[3:2] selects the adder B source, op[1:0] the logic unit)
    localparam logic [3:0] ALU_OP_ADD  = 4'b0011;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0111;
    localparam logic [3:0] ALU_OP_DBL  = 4'b1011;
    localparam logic [3:0] ALU_OP_PASS = 4'b1111;

    // Product width and final step index of the 8-step loop
    localparam int         PROD_W = 16;
    localparam logic [2:0] K_LAST = 3'd7;

endpackage : alu_mul_seq_pkg
`default_nettype wire

// File: rtl/alu_6502.sv
`default_nettype none
// ============================================================================
//  Module      : alu_6502
//  Description : 8-bit 6502-style ALU with registered outputs.
//                op[1:0] : logic unit (OR / AND / XOR / pass AI)
//                op[3:2] : adder B source (BI / ~BI / logic result / zero)
//                right   : shift logic result right, CI into bit 7,
//                          AI[0] out as carry
//                The carry input is not added for right shifts or op[3:2]=11.
//                Registers update only when RDY=1 and are never reset.
//  Ports       : clk, op, right, AI, BI, CI, BCD, RDY in;
//                OUT, CO, V, Z, N, HC out
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_6502 (
    input  logic       clk,
    input  logic [3:0] op,
    input  logic       right,
    input  logic [7:0] AI,
    input  logic [7:0] BI,
    input  logic       CI,
    input  logic       BCD,
    input  logic       RDY,
    output logic [7:0] OUT,
    output logic       CO,
    output logic       V,
    output logic       Z,
    output logic       N,
    output logic       HC
);

    logic [8:0] w_logic;
    logic [7:0] w_bi;
    logic       w_adder_ci;
    logic [4:0] w_sum_l;
    logic [4:0] w_sum_h;
    logic       w_hc9;
    logic       w_hc;
    logic       w_co9;

    always_comb begin
        w_logic = 9'd0;
        case (op[1:0])
            2'b00:   w_logic = {1'b0, AI | BI};
            2'b01:   w_logic = {1'b0, AI & BI};
            2'b10:   w_logic = {1'b0, AI ^ BI};
            default: w_logic = {1'b0, AI};
        endcase
        // Bit 8 carries the shifted-out LSB through the adder to CO
        if (right) begin
            w_logic = {AI[0], CI, AI[7:1]};
        end
    end

    always_comb begin
        w_bi = 8'd0;
        case (op[3:2])
            2'b00:   w_bi = BI;
            2'b01:   w_bi = ~BI;
            2'b10:   w_bi = w_logic[7:0];
            default: w_bi = 8'd0;
        endcase
    end

    assign w_adder_ci = (right | (op[3:2] == 2'b11)) ? 1'b0 : CI;

    assign w_sum_l = {1'b0, w_logic[3:0]} + {1'b0, w_bi[3:0]} + {4'd0, w_adder_ci};
    assign w_hc9   = BCD & (w_sum_l[3:1] >= 3'd5);
    assign w_hc    = w_sum_l[4] | w_hc9;
    assign w_sum_h = w_logic[8:4] + {1'b0, w_bi[7:4]} + {4'd0, w_hc};
    assign w_co9   = BCD & (w_sum_h[3:1] >= 3'd5);

    always_ff @(posedge clk) begin
        if (RDY) begin
            OUT <= {w_sum_h[3:0], w_sum_l[3:0]};
            CO  <= w_sum_h[4] | w_co9;
            N   <= w_sum_h[3];
            HC  <= w_hc;
            V   <= (AI[7] ~^ w_bi[7]) & (AI[7] ^ w_sum_h[3]);
        end
    end

    assign Z = ~|OUT;

endmodule : alu_6502
`default_nettype wire

// File: rtl/alu_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : alu_port_mux
//  Description : 2:1 selector of the ALU control bundle. When i_sel_seq is
//                high the multiply sequencer owns the ALU, otherwise the CPU
//                core controls pass straight through.
//                Only built when ALU_MULSEQ_PASSTHRU_EN is defined.
//  Ports       : i_sel_seq        - 1 = sequencer drives the ALU
//                i_seq_*          - sequencer control values
//                i_cpu_*          - core control values
//                o_*              - selected controls toward the ALU
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef ALU_MULSEQ_PASSTHRU_EN
module alu_port_mux (
    input  logic       i_sel_seq,
    input  logic [3:0] i_seq_op,
    input  logic       i_seq_right,
    input  logic [7:0] i_seq_AI,
    input  logic [7:0] i_seq_BI,
    input  logic       i_seq_CI,
    input  logic       i_seq_BCD,
    input  logic [3:0] i_cpu_op,
    input  logic       i_cpu_right,
    input  logic [7:0] i_cpu_AI,
    input  logic [7:0] i_cpu_BI,
    input  logic       i_cpu_CI,
    input  logic       i_cpu_BCD,
    output logic [3:0] o_op,
    output logic       o_right,
    output logic [7:0] o_AI,
    output logic [7:0] o_BI,
    output logic       o_CI,
    output logic       o_BCD
);

    assign o_op    = i_sel_seq ? i_seq_op    : i_cpu_op;
    assign o_right = i_sel_seq ? i_seq_right : i_cpu_right;
    assign o_AI    = i_sel_seq ? i_seq_AI    : i_cpu_AI;
    assign o_BI    = i_sel_seq ? i_seq_BI    : i_cpu_BI;
    assign o_CI    = i_sel_seq ? i_seq_CI    : i_cpu_CI;
    assign o_BCD   = i_sel_seq ? i_seq_BCD   : i_cpu_BCD;

endmodule : alu_port_mux
`endif
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : 8x8 unsigned shift-and-add multiplier that borrows the
//                shared 8-bit ALU for 17 cycles per operation. The partial
//                product high byte lives in the ALU's OUT/CO registers and is
//                fed back each step; low product bits are shifted into Q.
//                Optional feature macro: ALU_MULSEQ_PASSTHRU_EN
//                  defined   -> cpu_* ports exist and drive the ALU in IDLE
//                  undefined -> constant idle drive, ALU dedicated
//  Ports       : clk, reset (async, active high), RDY (global stall)
//                start/opa/opb      - request and operands
//                busy/done/prod     - status and 16-bit result
//                alu_* out          - ALU controls
//                alu_OUT/alu_CO in  - ALU registered result
//                cpu_* in           - core ALU controls (passthrough only)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RDY,
    input  logic              start,
    input  logic [7:0]        opa,
    input  logic [7:0]        opb,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] prod,
    output logic [3:0]        alu_op,
    output logic              alu_right,
    output logic [7:0]        alu_AI,
    output logic [7:0]        alu_BI,
    output logic              alu_CI,
    output logic              alu_BCD,
    output logic              alu_RDY,
`ifdef ALU_MULSEQ_PASSTHRU_EN
    input  logic [3:0]        cpu_op,
    input  logic              cpu_right,
    input  logic [7:0]        cpu_AI,
    input  logic [7:0]        cpu_BI,
    input  logic              cpu_CI,
    input  logic              cpu_BCD,
`endif
    input  logic [7:0]        alu_OUT,
    input  logic              alu_CO
);

    seq_state_t        r_state;
    logic [2:0]        r_k;
    logic [7:0]        r_m;
    logic [7:0]        r_q;
    logic [PROD_W-1:0] r_prod;
    logic              r_done;

    logic              w_busy;
    logic              w_bit;
    logic [3:0]        w_seq_op;
    logic              w_seq_right;
    logic [7:0]        w_seq_AI;
    logic [7:0]        w_seq_BI;
    logic              w_seq_CI;

    assign w_busy = (r_state != ST_IDLE);

    // Q only starts shifting at step 1 and the shift lands at the end of the
    // ADD step, so during ADD k (k>0) the original multiplier bit k sits in
    // Q[1]; at step 0 it is Q[0].
    assign w_bit = (r_k == 3'd0) ? r_q[0] : r_q[1];

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_k     <= 3'd0;
            r_m     <= 8'd0;
            r_q     <= 8'd0;
            r_prod  <= '0;
            r_done  <= 1'b0;
        end else if (RDY) begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m     <= opa;
                        r_q     <= opb;
                        r_k     <= 3'd0;
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    // alu_CO here is the LSB dropped by the previous SHR step
                    if (r_k != 3'd0) begin
                        r_q <= {alu_CO, r_q[7:1]};
                    end
                    r_state <= ST_SHR;
                end
                ST_SHR: begin
                    if (r_k == K_LAST) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        r_state <= ST_ADD;
                    end
                end
                ST_FIN: begin
                    // Final SHR left the high byte in OUT and product bit 7 in CO
                    r_prod  <= {alu_OUT, alu_CO, r_q[7:1]};
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer ALU drive; IDLE and FIN fall back to the idle pattern
    // ------------------------------------------------------------------
    always_comb begin
        w_seq_op    = ALU_OP_PASS;
        w_seq_right = 1'b0;
        w_seq_AI    = 8'h00;
        w_seq_BI    = 8'h00;
        w_seq_CI    = 1'b0;
        case (r_state)
            ST_ADD: begin
                // Step 0 starts from a zero accumulator, never from stale OUT
                w_seq_AI = (r_k == 3'd0) ? 8'h00 : alu_OUT;
                if (w_bit) begin
                    w_seq_op = ALU_OP_ADD;
                    w_seq_BI = r_m;
                end
            end
            ST_SHR: begin
                w_seq_right = 1'b1;
                w_seq_AI    = alu_OUT;
                w_seq_CI    = alu_CO;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU control output
    // ------------------------------------------------------------------
`ifdef ALU_MULSEQ_PASSTHRU_EN
    alu_port_mux u_port_mux (
        .i_sel_seq   (w_busy),
        .i_seq_op    (w_seq_op),
        .i_seq_right (w_seq_right),
        .i_seq_AI    (w_seq_AI),
        .i_seq_BI    (w_seq_BI),
        .i_seq_CI    (w_seq_CI),
        .i_seq_BCD   (1'b0),
        .i_cpu_op    (cpu_op),
        .i_cpu_right (cpu_right),
        .i_cpu_AI    (cpu_AI),
        .i_cpu_BI    (cpu_BI),
        .i_cpu_CI    (cpu_CI),
        .i_cpu_BCD   (cpu_BCD),
        .o_op        (alu_op),
        .o_right     (alu_right),
        .o_AI        (alu_AI),
        .o_BI        (alu_BI),
        .o_CI        (alu_CI),
        .o_BCD       (alu_BCD)
    );
`else
    assign alu_op    = w_seq_op;
    assign alu_right = w_seq_right;
    assign alu_AI    = w_seq_AI;
    assign alu_BI    = w_seq_BI;
    assign alu_CI    = w_seq_CI;
    assign alu_BCD   = 1'b0;
`endif

    assign alu_RDY = RDY;
    assign busy    = w_busy;
    assign done    = r_done;
    assign prod    = r_prod;

endmodule : alu_mul_seq
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mul_seq
//  Description : Self-checking bench for alu_mul_seq together with the real
//                alu_6502. Expected products come from plain multiplication,
//                expected latency from 18 cycles plus one per stalled cycle.
//                Honours ALU_MULSEQ_PASSTHRU_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

    logic        clk;
    logic        reset;
    logic        RDY;
    logic        start;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic        busy;
    logic        done;
    logic [15:0] prod;
    logic [3:0]  alu_op;
    logic        alu_right;
    logic [7:0]  alu_AI;
    logic [7:0]  alu_BI;
    logic        alu_CI;
    logic        alu_BCD;
    logic        alu_RDY;
    logic [7:0]  alu_OUT;
    logic        alu_CO;
    logic        alu_V;
    logic        alu_Z;
    logic        alu_N;
    logic        alu_HC;
`ifdef ALU_MULSEQ_PASSTHRU_EN
    logic [3:0]  cpu_op;
    logic        cpu_right;
    logic [7:0]  cpu_AI;
    logic [7:0]  cpu_BI;
    logic        cpu_CI;
    logic        cpu_BCD;
`endif

    int checks   = 0;
    int failures = 0;

    alu_mul_seq dut (
        .clk       (clk),
        .reset     (reset),
        .RDY       (RDY),
        .start     (start),
        .opa       (opa),
        .opb       (opb),
        .busy      (busy),
        .done      (done),
        .prod      (prod),
        .alu_op    (alu_op),
        .alu_right (alu_right),
        .alu_AI    (alu_AI),
        .alu_BI    (alu_BI),
        .alu_CI    (alu_CI),
        .alu_BCD   (alu_BCD),
        .alu_RDY   (alu_RDY),
`ifdef ALU_MULSEQ_PASSTHRU_EN
        .cpu_op    (cpu_op),
        .cpu_right (cpu_right),
        .cpu_AI    (cpu_AI),
        .cpu_BI    (cpu_BI),
        .cpu_CI    (cpu_CI),
        .cpu_BCD   (cpu_BCD),
`endif
        .alu_OUT   (alu_OUT),
        .alu_CO    (alu_CO)
    );

    alu_6502 u_alu (
        .clk   (clk),
        .op    (alu_op),
        .right (alu_right),
        .AI    (alu_AI),
        .BI    (alu_BI),
        .CI    (alu_CI),
        .BCD   (alu_BCD),
        .RDY   (alu_RDY),
        .OUT   (alu_OUT),
        .CO    (alu_CO),
        .V     (alu_V),
        .Z     (alu_Z),
        .N     (alu_N),
        .HC    (alu_HC)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: unsigned product
    function automatic logic [15:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
        return 16'(a) * 16'(b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one multiply (caller is #1 after an edge with the DUT idle),
    // optionally stall RDY over cycles [sf, sf+sc) and inject a stray start
    // in cycle inj. Returns in the cycle where done is seen (lat = cycle no.).
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input int sf, input int sc, input int inj,
                         output int lat, output logic [3:0] op1,
                         output logic r1, output logic r2, output logic ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b1;
        op1  = 4'h0;
        r1   = 1'b0;
        r2   = 1'b0;
        opa  = a;
        opb  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (!seen && lat <= 60) begin
            RDY = !(lat >= sf && lat < sf + sc);
            if (lat == inj) begin
                start = 1'b1;
                opa   = ~a;
                opb   = 8'hFF;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1)     ok = 1'b0;
                if (alu_BCD !== 1'b0)  ok = 1'b0;
                if (alu_RDY !== RDY)   ok = 1'b0;
                if (lat == 1) begin
                    op1 = alu_op;
                    r1  = alu_right;
                end
                if (lat == 2) r2 = alu_right;
                step();
                lat++;
            end
        end
        start = 1'b0;
        RDY   = 1'b1;
    endtask

    initial begin : main
        int         lat;
        logic [3:0] op1;
        logic       r1;
        logic       r2;
        logic       ok;
        logic [7:0] ra;
        logic [7:0] rb;
        int         sf;
        int         sc;

        reset = 1'b1;
        RDY   = 1'b1;
        start = 1'b0;
        opa   = 8'h00;
        opb   = 8'h00;
`ifdef ALU_MULSEQ_PASSTHRU_EN
        cpu_op    = 4'b0111;
        cpu_right = 1'b0;
        cpu_AI    = 8'h55;
        cpu_BI    = 8'h00;
        cpu_CI    = 1'b0;
        cpu_BCD   = 1'b0;
`endif
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prod", 32'(prod), 32'h0000);
        reset = 1'b0;
        step();

        // Idle ALU drive
`ifdef ALU_MULSEQ_PASSTHRU_EN
        check("idle_op_pt", 32'(alu_op), 32'h7);
        check("idle_ai_pt", 32'(alu_AI), 32'h55);
`else
        check("idle_op", 32'(alu_op), 32'hF);
        check("idle_ai", 32'(alu_AI), 32'h00);
        check("idle_bi", 32'(alu_BI), 32'h00);
        check("idle_ci_right", 32'({alu_CI, alu_right}), 32'h0);
`endif
        check("idle_bcd", 32'(alu_BCD), 32'd0);

        // FF x FF
        do_op(8'hFF, 8'hFF, 0, 0, 0, lat, op1, r1, r2, ok);
        check("ff_lat", 32'(lat), 32'd18);
        check("ff_prod", 32'(prod), 32'hFE01);
        check("ff_busy_seq", 32'(ok), 32'd1);
        check("ff_add0_op", 32'(op1), 32'h3);
        check("ff_add0_right", 32'(r1), 32'd0);
        check("ff_shr0_right", 32'(r2), 32'd1);
        check("ff_done_busy", 32'(busy), 32'd0);
`ifndef ALU_MULSEQ_PASSTHRU_EN
        check("ff_done_idle_op", 32'(alu_op), 32'hF);
`endif
        step();
        check("ff_done_pulse", 32'(done), 32'd0);
        check("ff_prod_hold", 32'(prod), 32'hFE01);

        // Zero multiplicand, then single carry into the high byte
        do_op(8'h00, 8'hA5, 0, 0, 0, lat, op1, r1, r2, ok);
        check("z_lat", 32'(lat), 32'd18);
        check("z_prod", 32'(prod), 32'h0000);
        check("z_add0_op", 32'(op1), 32'h3);
        step();
        do_op(8'h80, 8'h02, 0, 0, 0, lat, op1, r1, r2, ok);
        check("hi_prod", 32'(prod), 32'h0100);
        check("hi_add0_op", 32'(op1), 32'hF);
        check("hi_busy_seq", 32'(ok), 32'd1);
        step();

        // Stall cycles 6..10
        do_op(8'h0D, 8'h0B, 6, 5, 0, lat, op1, r1, r2, ok);
        check("stall_lat", 32'(lat), 32'd23);
        check("stall_prod", 32'(prod), 32'h008F);
        check("stall_seq", 32'(ok), 32'd1);
        RDY = 1'b0;
        step();
        check("stall_done_hold1", 32'(done), 32'd1);
        step();
        check("stall_done_hold2", 32'(done), 32'd1);
        check("stall_prod_hold", 32'(prod), 32'h008F);
        RDY = 1'b1;
        step();
        check("stall_done_clr", 32'(done), 32'd0);

        // Stray start while busy, then back-to-back start in the done cycle
        do_op(8'h07, 8'h09, 0, 0, 5, lat, op1, r1, r2, ok);
        check("inj_lat", 32'(lat), 32'd18);
        check("inj_prod", 32'(prod), 32'h003F);
        do_op(8'h03, 8'h05, 0, 0, 0, lat, op1, r1, r2, ok);
        check("b2b_lat", 32'(lat), 32'd18);
        check("b2b_prod", 32'(prod), 32'h000F);
        step();

        // Asynchronous reset in cycle 9 of an operation
        opa   = 8'h55;
        opb   = 8'h66;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_prod", 32'(prod), 32'h0000);
        step();
        reset = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        do_op(8'h12, 8'h34, 0, 0, 0, lat, op1, r1, r2, ok);
        check("post_rst_lat", 32'(lat), 32'd18);
        check("post_rst_prod", 32'(prod), 32'h03A8);
        step();

        // Randomized operands and stall windows against the reference model
        for (int n = 0; n < 10; n++) begin
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            sf = int'($urandom_range(17, 1));
            sc = int'($urandom_range(4, 0));
            do_op(ra, rb, sf, sc, 0, lat, op1, r1, r2, ok);
            check("rnd_lat", 32'(lat), 32'(18 + sc));
            check("rnd_prod", 32'(prod), 32'(mul_ref(ra, rb)));
            check("rnd_seq", 32'(ok), 32'd1);
            if ((n % 2) == 1) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_mul_seq
`default_nettype wire
